// File: rtl/imem_sequencer.sv
// Instruction-memory responder: accepts a program over a valid/ready load
// port, then streams one instruction per cycle with its address. At the end
// of the program, or on a halt, it drains the downstream pipeline with NOPs
// and then flags completion.
module imem_sequencer #(
    parameter int DEPTH        = 256,
    parameter int INSN_W       = 15,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [INSN_W-1:0] load_data,
    input  logic              start,
    input  logic              halt_req,
    output logic [7:0]        address_imem,
    output logic [INSN_W-1:0] q_imem,
    output logic              running,
    output logic              done,
    output logic [8:0]        count
);

    localparam int            AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            DW         = $clog2(DRAIN_CYCLES + 2);
    localparam logic [8:0]    DEPTH_C    = 9'(DEPTH);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [INSN_W-1:0] mem [DEPTH];
    logic [7:0]        pc, pc_nxt;
    logic [8:0]        count_nxt;
    logic [7:0]        addr_nxt;
    logic [DW-1:0]     drain_cnt, drain_nxt;
    logic              load_fire;
    logic              fetch;
    logic              nop;

    // Next-state, next-register and output-select decode for the sequencer.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        count_nxt  = count;
        addr_nxt   = address_imem;
        drain_nxt  = drain_cnt;
        load_fire  = 1'b0;
        fetch      = 1'b0;
        nop        = 1'b0;
        load_ready = (state == IDLE) && (count < DEPTH_C);

        if (clear) begin
            // Clear wins over every in-flight activity, including a load.
            state_nxt = IDLE;
            count_nxt = 9'd0;
            pc_nxt    = 8'd0;
            addr_nxt  = 8'd0;
            drain_nxt = '0;
            nop       = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    nop = 1'b1;
                    if (load_valid && load_ready) begin
                        load_fire = 1'b1;
                        count_nxt = count + 9'd1;
                    end
                    // A load in the start cycle is part of the program.
                    if (start && (count_nxt != 9'd0)) begin
                        state_nxt = RUN;
                        pc_nxt    = 8'd0;
                    end
                end
                RUN: begin
                    if (halt_req) begin
                        // Instruction at pc is dropped; address holds.
                        nop       = 1'b1;
                        state_nxt = DRAIN;
                        drain_nxt = '0;
                    end else begin
                        fetch    = 1'b1;
                        addr_nxt = pc;
                        pc_nxt   = pc + 8'd1;
                        if ({1'b0, pc} == (count - 9'd1)) begin
                            state_nxt = DRAIN;
                            drain_nxt = '0;
                        end
                    end
                end
                DRAIN: begin
                    // DRAIN_CYCLES NOP edges, then one more edge to DONE.
                    nop = 1'b1;
                    if (drain_cnt == DRAIN_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        drain_nxt = drain_cnt + DW'(1);
                    end
                end
                DONE: begin
                    nop = 1'b1;
                    if (start) begin
                        state_nxt = RUN;
                        pc_nxt    = 8'd0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    nop       = 1'b1;
                end
            endcase
        end
    end

    // Control and status registers; status flags follow the next state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            pc           <= 8'd0;
            count        <= 9'd0;
            address_imem <= 8'd0;
            drain_cnt    <= '0;
            running      <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            count        <= count_nxt;
            address_imem <= addr_nxt;
            drain_cnt    <= drain_nxt;
            running      <= (state_nxt == RUN) || (state_nxt == DRAIN);
            done         <= (state_nxt == DONE);
        end
    end

    // Instruction output register: synchronous read of the program memory.
    always_ff @(posedge clock) begin
        if (!reset || nop) begin
            q_imem <= '0;
        end else if (fetch) begin
            q_imem <= mem[pc[AW-1:0]];
        end
    end

    // Program memory write port; contents survive reset and clear.
    always_ff @(posedge clock) begin
        if (reset && load_fire) begin
            mem[count[AW-1:0]] <= load_data;
        end
    end

endmodule

// File: tb/tb_imem_sequencer.sv
// Directed self-checking bench for imem_sequencer.
module tb_imem_sequencer;

    logic        clock;
    logic        reset;
    logic        clear;
    logic        load_valid;
    logic        load_ready;
    logic [14:0] load_data;
    logic        start;
    logic        halt_req;
    logic [7:0]  address_imem;
    logic [14:0] q_imem;
    logic        running;
    logic        done;
    logic [8:0]  count;

    int vectors;
    int miscompares;

    logic [14:0] prog3 [3] = '{15'h1234, 15'h0ABC, 15'h7FFF};

    imem_sequencer #(.DEPTH(256), .INSN_W(15), .DRAIN_CYCLES(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .clear        (clear),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .start        (start),
        .halt_req     (halt_req),
        .address_imem (address_imem),
        .q_imem       (q_imem),
        .running      (running),
        .done         (done),
        .count        (count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input logic [14:0] d);
        load_valid = 1'b1;
        load_data  = d;
        step();
        load_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        vectors++; if (q_imem !== 15'd0) begin miscompares++; $display("FAIL reset_q: got %h want 0", q_imem); end
        vectors++; if (address_imem !== 8'd0) begin miscompares++; $display("FAIL reset_addr: got %0d want 0", address_imem); end
        vectors++; if (count !== 9'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
        vectors++; if (running !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL reset_flags: got running=%b done=%b want 0 0", running, done); end
        vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", load_ready); end
        reset = 1'b1;
    endtask

    task automatic test_basic_run();
        for (int i = 0; i < 3; i++) load_word(prog3[i]);
        vectors++; if (count !== 9'd3) begin miscompares++; $display("FAIL basic_count: got %0d want 3", count); end
        start = 1'b1;
        step();
        start = 1'b0;
        vectors++; if (running !== 1'b1 || q_imem !== 15'd0) begin miscompares++; $display("FAIL basic_enter_run: got running=%b q=%h want 1 0000", running, q_imem); end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (q_imem !== prog3[i] || address_imem !== 8'(i)) begin miscompares++; $display("FAIL basic_issue%0d: got q=%h a=%0d want q=%h a=%0d", i, q_imem, address_imem, prog3[i], i); end
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (q_imem !== 15'd0 || address_imem !== 8'd2 || running !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL basic_drain%0d: got q=%h a=%0d r=%b d=%b want 0000 2 1 0", i, q_imem, address_imem, running, done); end
        end
        step();
        vectors++; if (done !== 1'b1 || running !== 1'b0 || q_imem !== 15'd0) begin miscompares++; $display("FAIL basic_done: got d=%b r=%b q=%h want 1 0 0000", done, running, q_imem); end
    endtask

    task automatic test_full_memory();
        do_clear();
        vectors++; if (count !== 9'd0) begin miscompares++; $display("FAIL full_clear: got %0d want 0", count); end
        for (int i = 0; i < 256; i++) begin
            vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL full_ready%0d: got %b want 1", i, load_ready); end
            load_word(15'(i));
        end
        vectors++; if (count !== 9'd256 || load_ready !== 1'b0) begin miscompares++; $display("FAIL full_at256: got count=%0d ready=%b want 256 0", count, load_ready); end
        load_word(15'h5555);
        vectors++; if (count !== 9'd256) begin miscompares++; $display("FAIL full_257th: got %0d want 256", count); end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            step();
            vectors++; if (q_imem !== 15'(i) || address_imem !== 8'(i)) begin miscompares++; $display("FAIL full_issue%0d: got q=%h a=%0d want q=%h a=%0d", i, q_imem, address_imem, 15'(i), i); end
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (q_imem !== 15'd0 || address_imem !== 8'd255 || done !== 1'b0) begin miscompares++; $display("FAIL full_drain%0d: got q=%h a=%0d d=%b want 0000 255 0", i, q_imem, address_imem, done); end
        end
        step();
        vectors++; if (done !== 1'b1 || running !== 1'b0) begin miscompares++; $display("FAIL full_done: got d=%b r=%b want 1 0", done, running); end
    endtask

    task automatic test_halt();
        do_clear();
        for (int i = 0; i < 10; i++) load_word(15'h0100 + 15'(i));
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++; if (q_imem !== 15'h0100 + 15'(i) || address_imem !== 8'(i)) begin miscompares++; $display("FAIL halt_issue%0d: got q=%h a=%0d want q=%h a=%0d", i, q_imem, address_imem, 15'h0100 + 15'(i), i); end
        end
        // Held high through the drain, where it must have no effect.
        halt_req = 1'b1;
        step();
        vectors++; if (q_imem !== 15'd0 || address_imem !== 8'd1 || running !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL halt_edge: got q=%h a=%0d r=%b d=%b want 0000 1 1 0", q_imem, address_imem, running, done); end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (q_imem !== 15'd0 || address_imem !== 8'd1 || done !== 1'b0) begin miscompares++; $display("FAIL halt_drain%0d: got q=%h a=%0d d=%b want 0000 1 0", i, q_imem, address_imem, done); end
        end
        step();
        halt_req = 1'b0;
        vectors++; if (done !== 1'b1 || running !== 1'b0 || q_imem !== 15'd0) begin miscompares++; $display("FAIL halt_done: got d=%b r=%b q=%h want 1 0 0000", done, running, q_imem); end
    endtask

    task automatic test_restart_and_empty_start();
        start = 1'b1;
        step();
        start = 1'b0;
        vectors++; if (running !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL restart_enter: got r=%b d=%b want 1 0", running, done); end
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++; if (q_imem !== 15'h0100 + 15'(i) || address_imem !== 8'(i)) begin miscompares++; $display("FAIL restart_issue%0d: got q=%h a=%0d want q=%h a=%0d", i, q_imem, address_imem, 15'h0100 + 15'(i), i); end
        end
        for (int i = 0; i < 4; i++) step();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL restart_done: got %b want 1", done); end
        do_clear();
        start = 1'b1;
        step();
        start = 1'b0;
        vectors++; if (running !== 1'b0 || q_imem !== 15'd0 || done !== 1'b0) begin miscompares++; $display("FAIL empty_start: got r=%b q=%h d=%b want 0 0000 0", running, q_imem, done); end
        step();
        vectors++; if (running !== 1'b0 || q_imem !== 15'd0 || load_ready !== 1'b1) begin miscompares++; $display("FAIL empty_idle: got r=%b q=%h ready=%b want 0 0000 1", running, q_imem, load_ready); end
    endtask

    task automatic test_simultaneous();
        load_word(15'h0011);
        load_word(15'h0022);
        clear      = 1'b1;
        load_valid = 1'b1;
        load_data  = 15'h0033;
        step();
        clear      = 1'b0;
        load_valid = 1'b0;
        vectors++; if (count !== 9'd0) begin miscompares++; $display("FAIL clear_load: got %0d want 0", count); end
        load_word(15'h0A01);
        load_word(15'h0A02);
        start      = 1'b1;
        load_valid = 1'b1;
        load_data  = 15'h0A03;
        step();
        start      = 1'b0;
        load_valid = 1'b0;
        vectors++; if (count !== 9'd3 || running !== 1'b1) begin miscompares++; $display("FAIL start_load: got count=%0d r=%b want 3 1", count, running); end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (q_imem !== 15'h0A01 + 15'(i) || address_imem !== 8'(i)) begin miscompares++; $display("FAIL start_load_issue%0d: got q=%h a=%0d want q=%h a=%0d", i, q_imem, address_imem, 15'h0A01 + 15'(i), i); end
        end
        step();
        vectors++; if (q_imem !== 15'd0 || address_imem !== 8'd2) begin miscompares++; $display("FAIL start_load_end: got q=%h a=%0d want 0000 2", q_imem, address_imem); end
    endtask

    task automatic test_reset_mid_run();
        do_clear();
        for (int i = 0; i < 5; i++) load_word(15'h0200 + 15'(i));
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        vectors++; if (q_imem !== 15'h0201 || address_imem !== 8'd1) begin miscompares++; $display("FAIL midrun_pre: got q=%h a=%0d want 0201 1", q_imem, address_imem); end
        reset = 1'b0;
        step();
        reset = 1'b1;
        vectors++; if (q_imem !== 15'd0 || address_imem !== 8'd0 || running !== 1'b0 || count !== 9'd0 || load_ready !== 1'b1) begin miscompares++; $display("FAIL midrun_reset: got q=%h a=%0d r=%b c=%0d ready=%b want 0000 0 0 0 1", q_imem, address_imem, running, count, load_ready); end
        step();
        vectors++; if (q_imem !== 15'd0 || running !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL midrun_after: got q=%h r=%b d=%b want 0000 0 0", q_imem, running, done); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        clear       = 1'b0;
        load_valid  = 1'b0;
        load_data   = 15'd0;
        start       = 1'b0;
        halt_req    = 1'b0;
        test_reset();
        test_basic_run();
        test_full_memory();
        test_halt();
        test_restart_and_empty_start();
        test_simultaneous();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
